// File: rtl/chess_move_commit.sv
// chess_move_commit: sole owner of the 8x8 board. Turns cursor selections
// into committed moves: source pick, destination check against the move
// generator's legal map, board write, promotion, capture report, turn flip.
module chess_move_commit #(
    parameter logic [2:0] PROMOTE_TYPE = 3'b101,
    parameter logic       START_TURN   = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [2:0]   cur_row,
    input  logic [2:0]   cur_col,
    input  logic         sel_pulse,
    input  logic         cancel_pulse,
    input  logic [63:0]  legal_dest,
    output logic [319:0] board_flat,
    output logic [2:0]   src_row,
    output logic [2:0]   src_col,
    output logic         src_valid,
    output logic         turn,
    output logic         move_done,
    output logic [4:0]   captured,
    output logic         illegal,
    output logic         game_over
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SRC_HELD = 2'd1,
        COMMIT   = 2'd2,
        OVER     = 2'd3
    } state_t;

    localparam logic [2:0] TYPE_PAWN = 3'b001;
    localparam logic [2:0] TYPE_KING = 3'b110;

    // Opening position for one square; index is row*8+col.
    function automatic logic [4:0] start_piece(input logic [5:0] idx);
        logic [2:0] row;
        logic [2:0] col;
        logic [2:0] back_type;
        row = idx[5:3];
        col = idx[2:0];
        case (col)
            3'd0, 3'd7: back_type = 3'b100;
            3'd1, 3'd6: back_type = 3'b010;
            3'd2, 3'd5: back_type = 3'b011;
            3'd3:       back_type = 3'b101;
            default:    back_type = 3'b110;
        endcase
        case (row)
            3'd0:    start_piece = {back_type, 2'b11};
            3'd1:    start_piece = {TYPE_PAWN, 2'b11};
            3'd6:    start_piece = {TYPE_PAWN, 2'b01};
            3'd7:    start_piece = {back_type, 2'b01};
            default: start_piece = 5'b00000;
        endcase
    endfunction

    state_t      state_reg, state_next;
    logic [2:0]  src_row_reg, src_row_next;
    logic [2:0]  src_col_reg, src_col_next;
    logic        src_valid_reg, src_valid_next;
    logic [2:0]  dst_row_reg, dst_row_next;
    logic [2:0]  dst_col_reg, dst_col_next;
    logic        turn_reg, turn_next;
    logic        move_done_reg, move_done_next;
    logic        illegal_reg, illegal_next;
    logic [4:0]  captured_reg, captured_next;

    logic [4:0]  board_arr [64];
    logic [5:0]  cur_idx;
    logic [5:0]  src_idx;
    logic [5:0]  dst_idx;
    logic [4:0]  cur_piece;
    logic [4:0]  src_piece;
    logic [4:0]  dst_old;
    logic [4:0]  dst_piece;
    logic        cur_own;
    logic        promote;
    logic        commit_fire;

    assign cur_idx     = {cur_row, cur_col};
    assign src_idx     = {src_row_reg, src_col_reg};
    assign dst_idx     = {dst_row_reg, dst_col_reg};
    assign cur_piece   = board_arr[cur_idx];
    assign src_piece   = board_arr[src_idx];
    assign dst_old     = board_arr[dst_idx];
    assign cur_own     = cur_piece[0] && (cur_piece[1] == turn_reg);
    assign commit_fire = (state_reg == COMMIT);

    // A pawn reaching the far rank for its colour becomes PROMOTE_TYPE.
    assign promote   = (src_piece[4:2] == TYPE_PAWN) &&
                       ((!src_piece[1] && dst_row_reg == 3'd0) ||
                        ( src_piece[1] && dst_row_reg == 3'd7));
    assign dst_piece = promote ? {PROMOTE_TYPE, src_piece[1:0]} : src_piece;

    // One register per square; only the held source and destination change,
    // and only on the COMMIT cycle. src and dst are never the same square.
    generate
        for (genvar gi = 0; gi < 64; gi++) begin : g_sq
            localparam logic [4:0] START_VAL = start_piece(6'(gi));
            logic [4:0] sq_reg;

            // Square register: start position on reset, move write on commit.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    sq_reg <= START_VAL;
                end else if (commit_fire) begin
                    if (dst_idx == 6'(gi)) begin
                        sq_reg <= dst_piece;
                    end else if (src_idx == 6'(gi)) begin
                        sq_reg <= 5'b00000;
                    end
                end
            end

            assign board_arr[gi]         = sq_reg;
            assign board_flat[gi*5 +: 5] = sq_reg;
        end
    endgenerate

    // Control state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            src_row_reg   <= 3'd0;
            src_col_reg   <= 3'd0;
            src_valid_reg <= 1'b0;
            dst_row_reg   <= 3'd0;
            dst_col_reg   <= 3'd0;
            turn_reg      <= START_TURN;
            move_done_reg <= 1'b0;
            illegal_reg   <= 1'b0;
            captured_reg  <= 5'b00000;
        end else begin
            state_reg     <= state_next;
            src_row_reg   <= src_row_next;
            src_col_reg   <= src_col_next;
            src_valid_reg <= src_valid_next;
            dst_row_reg   <= dst_row_next;
            dst_col_reg   <= dst_col_next;
            turn_reg      <= turn_next;
            move_done_reg <= move_done_next;
            illegal_reg   <= illegal_next;
            captured_reg  <= captured_next;
        end
    end

    // Next-state and pulse decode. Cancel always wins over a same-cycle sel.
    always_comb begin
        state_next     = state_reg;
        src_row_next   = src_row_reg;
        src_col_next   = src_col_reg;
        src_valid_next = src_valid_reg;
        dst_row_next   = dst_row_reg;
        dst_col_next   = dst_col_reg;
        turn_next      = turn_reg;
        move_done_next = 1'b0;
        illegal_next   = 1'b0;
        captured_next  = captured_reg;

        case (state_reg)
            IDLE: begin
                if (!cancel_pulse && sel_pulse) begin
                    if (cur_own) begin
                        src_row_next   = cur_row;
                        src_col_next   = cur_col;
                        src_valid_next = 1'b1;
                        state_next     = SRC_HELD;
                    end else begin
                        illegal_next = 1'b1;
                    end
                end
            end
            SRC_HELD: begin
                if (cancel_pulse) begin
                    src_valid_next = 1'b0;
                    state_next     = IDLE;
                end else if (sel_pulse) begin
                    // Own-piece reselect takes precedence over a legal bit.
                    if (cur_own) begin
                        src_row_next = cur_row;
                        src_col_next = cur_col;
                    end else if (legal_dest[cur_idx]) begin
                        dst_row_next = cur_row;
                        dst_col_next = cur_col;
                        state_next   = COMMIT;
                    end else begin
                        illegal_next = 1'b1;
                    end
                end
            end
            COMMIT: begin
                captured_next  = dst_old;
                turn_next      = ~turn_reg;
                src_valid_next = 1'b0;
                move_done_next = 1'b1;
                if (dst_old[0] && dst_old[4:2] == TYPE_KING) begin
                    state_next = OVER;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                // OVER: frozen until reset.
                state_next = OVER;
            end
        endcase
    end

    assign src_row   = src_row_reg;
    assign src_col   = src_col_reg;
    assign src_valid = src_valid_reg;
    assign turn      = turn_reg;
    assign move_done = move_done_reg;
    assign illegal   = illegal_reg;
    assign captured  = captured_reg;
    assign game_over = (state_reg == OVER);

endmodule

// File: tb/tb_chess_move_commit.sv
// Directed bench for chess_move_commit: plays a short scripted game with
// hand-computed board contents and checks pulses, capture and game end.
module tb_chess_move_commit;

    logic         clk;
    logic         reset;
    logic [2:0]   cur_row;
    logic [2:0]   cur_col;
    logic         sel_pulse;
    logic         cancel_pulse;
    logic [63:0]  legal_dest;
    logic [319:0] board_flat;
    logic [2:0]   src_row;
    logic [2:0]   src_col;
    logic         src_valid;
    logic         turn;
    logic         move_done;
    logic [4:0]   captured;
    logic         illegal;
    logic         game_over;

    int total = 0;
    int bad   = 0;

    logic [4:0] exp_sq [64];

    chess_move_commit dut (
        .clk          (clk),
        .reset        (reset),
        .cur_row      (cur_row),
        .cur_col      (cur_col),
        .sel_pulse    (sel_pulse),
        .cancel_pulse (cancel_pulse),
        .legal_dest   (legal_dest),
        .board_flat   (board_flat),
        .src_row      (src_row),
        .src_col      (src_col),
        .src_valid    (src_valid),
        .turn         (turn),
        .move_done    (move_done),
        .captured     (captured),
        .illegal      (illegal),
        .game_over    (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] sq(input logic [2:0] r, input logic [2:0] c);
        int idx;
        idx = int'({r, c});
        return board_flat[idx*5 +: 5];
    endfunction

    function automatic logic [319:0] exp_flat();
        logic [319:0] v;
        for (int i = 0; i < 64; i++) v[i*5 +: 5] = exp_sq[i];
        return v;
    endfunction

    // Expected opening position, written out row by row.
    task automatic load_start();
        logic [4:0] row0 [8];
        logic [4:0] row7 [8];
        row0 = '{5'b10011, 5'b01011, 5'b01111, 5'b10111, 5'b11011, 5'b01111, 5'b01011, 5'b10011};
        row7 = '{5'b10001, 5'b01001, 5'b01101, 5'b10101, 5'b11001, 5'b01101, 5'b01001, 5'b10001};
        for (int c = 0; c < 8; c++) begin
            exp_sq[c]      = row0[c];
            exp_sq[8 + c]  = 5'b00111;
            exp_sq[48 + c] = 5'b00101;
            exp_sq[56 + c] = row7[c];
            for (int r = 2; r < 6; r++) exp_sq[r*8 + c] = 5'b00000;
        end
    endtask

    // One select cycle; entered and left on a falling edge.
    task automatic pulse_sel(input logic [2:0] r, input logic [2:0] c,
                             input logic [63:0] ld, input logic canc);
        cur_row = r; cur_col = c; legal_dest = ld;
        sel_pulse = 1'b1; cancel_pulse = canc;
        @(negedge clk);
        sel_pulse = 1'b0; cancel_pulse = 1'b0; legal_dest = '0;
        $display("sel (%0d,%0d) cancel=%0b -> src_valid=%0b illegal=%0b", r, c, canc, src_valid, illegal);
    endtask

    // Full move; returns in the cycle where move_done is high.
    task automatic do_move(input logic [2:0] sr, input logic [2:0] sc,
                           input logic [2:0] dr, input logic [2:0] dc);
        logic [63:0] ld;
        ld = 64'd1 << {dr, dc};
        pulse_sel(sr, sc, '0, 1'b0);
        pulse_sel(dr, dc, ld, 1'b0);
        @(negedge clk);
        $display("move (%0d,%0d)->(%0d,%0d) move_done=%0b captured=%b turn=%0b", sr, sc, dr, dc, move_done, captured, turn);
    endtask

    task automatic test_reset();
        reset = 1'b0; sel_pulse = 0; cancel_pulse = 0; legal_dest = '0; cur_row = 0; cur_col = 0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        load_start();
        total++; if (board_flat !== exp_flat()) begin bad++; $display("FAIL reset_board got=%h want=%h", board_flat, exp_flat()); end
        total++; if (sq(7,4) !== 5'b11001) begin bad++; $display("FAIL reset_sq74 got=%b want=11001", sq(7,4)); end
        total++; if (sq(1,0) !== 5'b00111) begin bad++; $display("FAIL reset_sq10 got=%b want=00111", sq(1,0)); end
        total++; if ({turn, src_valid, move_done, illegal, game_over} !== 5'b0) begin bad++; $display("FAIL reset_flags got=%b want=00000", {turn, src_valid, move_done, illegal, game_over}); end
        total++; if ({src_row, src_col, captured} !== 11'd0) begin bad++; $display("FAIL reset_regs got=%h want=0", {src_row, src_col, captured}); end
    endtask

    task automatic test_basic_move();
        pulse_sel(3'd6, 3'd4, '0, 1'b0);
        total++; if ({src_valid, src_row, src_col, illegal} !== {1'b1, 3'd6, 3'd4, 1'b0}) begin bad++; $display("FAIL src_latch got=%b want=11101000", {src_valid, src_row, src_col, illegal}); end
        pulse_sel(3'd4, 3'd4, 64'd1 << 36, 1'b0);
        total++; if (move_done !== 1'b0 || board_flat !== exp_flat()) begin bad++; $display("FAIL commit_early got=%b want=0", move_done); end
        @(negedge clk);
        exp_sq[36] = 5'b00101; exp_sq[52] = 5'b00000;
        total++; if (sq(4,4) !== 5'b00101 || sq(6,4) !== 5'b00000) begin bad++; $display("FAIL pawn_move got=%b/%b want=00101/00000", sq(4,4), sq(6,4)); end
        total++; if ({move_done, turn, src_valid, captured} !== {1'b1, 1'b1, 1'b0, 5'b0}) begin bad++; $display("FAIL move_flags got=%b want=11000000", {move_done, turn, src_valid, captured}); end
        @(negedge clk);
        total++; if (move_done !== 1'b0) begin bad++; $display("FAIL move_done_len got=%b want=0", move_done); end
        total++; if (board_flat !== exp_flat()) begin bad++; $display("FAIL board_after_move got=%h want=%h", board_flat, exp_flat()); end
    endtask

    task automatic test_illegal();
        pulse_sel(3'd6, 3'd0, '0, 1'b0);
        total++; if ({illegal, src_valid} !== 2'b10) begin bad++; $display("FAIL illegal_opp got=%b want=10", {illegal, src_valid}); end
        @(negedge clk);
        total++; if (illegal !== 1'b0) begin bad++; $display("FAIL illegal_len got=%b want=0", illegal); end
        pulse_sel(3'd3, 3'd3, '0, 1'b0);
        total++; if ({illegal, src_valid} !== 2'b10) begin bad++; $display("FAIL illegal_empty got=%b want=10", {illegal, src_valid}); end
        pulse_sel(3'd5, 3'd5, '0, 1'b1);
        total++; if (illegal !== 1'b0 || board_flat !== exp_flat()) begin bad++; $display("FAIL idle_cancel got=%b want=0", illegal); end
    endtask

    task automatic test_cancel();
        pulse_sel(3'd1, 3'd0, '0, 1'b0);
        total++; if ({src_valid, src_row, src_col} !== {1'b1, 3'd1, 3'd0}) begin bad++; $display("FAIL black_src got=%b want=1001000", {src_valid, src_row, src_col}); end
        pulse_sel(3'd1, 3'd1, 64'd1 << 9, 1'b0);
        total++; if ({src_valid, src_row, src_col, illegal} !== {1'b1, 3'd1, 3'd1, 1'b0}) begin bad++; $display("FAIL reselect got=%b want=10010010", {src_valid, src_row, src_col, illegal}); end
        pulse_sel(3'd5, 3'd5, '0, 1'b0);
        total++; if ({illegal, src_valid} !== 2'b11) begin bad++; $display("FAIL held_illegal got=%b want=11", {illegal, src_valid}); end
        pulse_sel(3'd1, 3'd0, '0, 1'b0);
        pulse_sel(3'd3, 3'd0, 64'd1 << 24, 1'b1);
        total++; if (src_valid !== 1'b0) begin bad++; $display("FAIL cancel_src got=%b want=0", src_valid); end
        @(negedge clk);
        total++; if ({move_done, turn} !== 2'b01 || board_flat !== exp_flat()) begin bad++; $display("FAIL cancel_nomove got=%b want=01", {move_done, turn}); end
    endtask

    task automatic test_promotion();
        do_move(3'd0, 3'd3, 3'd2, 3'd3);
        exp_sq[3] = 5'b00000; exp_sq[19] = 5'b10111;
        total++; if ({turn, captured} !== 6'b0 || sq(2,3) !== 5'b10111) begin bad++; $display("FAIL black_queen got=%b want=10111", sq(2,3)); end
        do_move(3'd6, 3'd3, 3'd1, 3'd3);
        exp_sq[51] = 5'b00000; exp_sq[11] = 5'b00101;
        total++; if (captured !== 5'b00111 || sq(1,3) !== 5'b00101) begin bad++; $display("FAIL pawn_capture got=%b want=00111", captured); end
        do_move(3'd1, 3'd0, 3'd2, 3'd0);
        exp_sq[8] = 5'b00000; exp_sq[16] = 5'b00111;
        do_move(3'd1, 3'd3, 3'd0, 3'd3);
        exp_sq[11] = 5'b00000; exp_sq[3] = 5'b10101;
        total++; if (sq(0,3) !== 5'b10101 || sq(1,3) !== 5'b00000) begin bad++; $display("FAIL promote got=%b want=10101", sq(0,3)); end
        total++; if ({turn, captured, move_done} !== {1'b1, 5'b0, 1'b1}) begin bad++; $display("FAIL promote_flags got=%b want=1000001", {turn, captured, move_done}); end
        total++; if (board_flat !== exp_flat()) begin bad++; $display("FAIL board_promote got=%h want=%h", board_flat, exp_flat()); end
    endtask

    task automatic test_king_capture();
        do_move(3'd1, 3'd1, 3'd2, 3'd1);
        exp_sq[9] = 5'b00000; exp_sq[17] = 5'b00111;
        total++; if (game_over !== 1'b0 || turn !== 1'b0) begin bad++; $display("FAIL pre_over got=%b want=00", {game_over, turn}); end
        do_move(3'd0, 3'd3, 3'd0, 3'd4);
        exp_sq[3] = 5'b00000; exp_sq[4] = 5'b10101;
        total++; if (captured !== 5'b11011) begin bad++; $display("FAIL king_captured got=%b want=11011", captured); end
        total++; if ({game_over, move_done, turn, illegal} !== 4'b1110) begin bad++; $display("FAIL over_flags got=%b want=1110", {game_over, move_done, turn, illegal}); end
        pulse_sel(3'd1, 3'd7, '0, 1'b0);
        total++; if ({illegal, src_valid, move_done} !== 3'b0) begin bad++; $display("FAIL over_sel_own got=%b want=000", {illegal, src_valid, move_done}); end
        pulse_sel(3'd5, 3'd5, 64'd1 << 45, 1'b0);
        total++; if (illegal !== 1'b0 || game_over !== 1'b1) begin bad++; $display("FAIL over_sel_empty got=%b want=01", {illegal, game_over}); end
        repeat (2) @(negedge clk);
        total++; if (board_flat !== exp_flat()) begin bad++; $display("FAIL over_frozen got=%h want=%h", board_flat, exp_flat()); end
    endtask

    task automatic test_reset_mid_commit();
        reset = 1'b0;
        #1;
        load_start();
        total++; if (board_flat !== exp_flat() || {game_over, turn} !== 2'b00) begin bad++; $display("FAIL reset_from_over got=%b want=00", {game_over, turn}); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        pulse_sel(3'd6, 3'd0, '0, 1'b0);
        pulse_sel(3'd5, 3'd0, 64'd1 << 40, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++; if (board_flat !== exp_flat()) begin bad++; $display("FAIL abort_board got=%h want=%h", board_flat, exp_flat()); end
        total++; if ({move_done, turn, src_valid} !== 3'b000) begin bad++; $display("FAIL abort_flags got=%b want=000", {move_done, turn, src_valid}); end
    endtask

    initial begin
        reset = 1'b0;
        test_reset();
        test_basic_move();
        test_illegal();
        test_cancel();
        test_promotion();
        test_king_capture();
        test_reset_mid_commit();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/chess_move_commit.md
Name: chess_move_commit

Overview:
- Owns the 8x8 board state register and is its only writer.
- Takes the player's cursor selections and checks each requested destination against the legal-destination map from the move generator.
- Commits legal moves into the board: piece write, source clear, pawn promotion, capture reporting, turn toggle.
- Exports the flattened board to the move generator and VGA renderer; sits between positionCounter (cursor) and the move-generation/display logic.

Parameters:
- PROMOTE_TYPE, 3'b101, piece type written on pawn promotion (101 = queen).
- START_TURN, 1'b0, side to move after reset (0 = white, 1 = black).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- cur_row  in  3  cursor row, 0 = black back rank, 7 = white back rank
- cur_col  in  3  cursor column
- sel_pulse  in  1  one-cycle select request
- cancel_pulse  in  1  one-cycle cancel request
- legal_dest  in  64  legal destinations for the square on src_row/src_col; bit index row*8+col; valid combinationally while src_valid=1
- board_flat  out  320  board state; square (r,c) occupies bits [(r*8+c)*5+4 : (r*8+c)*5]
- src_row  out  3  held source row
- src_col  out  3  held source column
- src_valid  out  1  a source square is held
- turn  out  1  side to move (0 white, 1 black)
- move_done  out  1  one-cycle pulse after a move is committed
- captured  out  5  previous content of the last destination square (00000 if no capture)
- illegal  out  1  one-cycle pulse on a rejected select
- game_over  out  1  set when a king is captured

Behaviour:
- Square encoding: bit0 = occupied; bit1 = colour (0 white, 1 black; 0 when empty); bits4:2 = type (001 pawn, 010 knight, 011 bishop, 100 rook, 101 queen, 110 king).
- Reset (async, reset=0), board loads the start position:
  - row0: 10011 01011 01111 10111 11011 01111 01011 10011
  - row1: all 00111
  - rows2-5: all 00000
  - row6: all 00101
  - row7: 10001 01001 01101 10101 11001 01101 01001 10001
- Reset values of outputs: turn=START_TURN; src_row=src_col=0; src_valid=0; move_done=0; illegal=0; captured=0; game_over=0; state=IDLE.
- Reset mid-commit aborts the commit; the board returns to the start position.
- "Own piece" means bit0=1 and bit1=turn.
- FSM states: IDLE, SRC_HELD, COMMIT, OVER.
- IDLE:
  - sel on own piece: latch src=cursor, src_valid=1, go to SRC_HELD.
  - sel on empty square or opponent piece: illegal=1 for one cycle, stay in IDLE.
  - cancel: no effect.
- SRC_HELD:
  - cancel: src_valid=0, go to IDLE.
  - sel on own piece (including src itself): re-latch src to the cursor square, stay in SRC_HELD.
  - sel with legal_dest[cur_row*8+cur_col]=1: latch dst=cursor, go to COMMIT.
  - any other sel: illegal pulse, stay in SRC_HELD.
- SRC_HELD priority: cancel beats sel when both arrive in the same cycle, in every state.
- COMMIT (exactly one cycle); on its closing edge:
  - board[dst] <= source piece, with type replaced by PROMOTE_TYPE when type=001 and (white and dst row=0, or black and dst row=7).
  - board[src] <= 00000.
  - captured <= old board[dst].
  - turn toggles; src_valid <= 0; move_done <= 1 for one cycle.
  - Next state is OVER if old board[dst] type was 110 and bit0=1; otherwise IDLE.
  - sel/cancel sampled during COMMIT are ignored.
- Latency: accepted destination sel at edge N, board updated at edge N+1, move_done high during cycle N+1..N+2.
- OVER: game_over=1; board frozen; all sel/cancel ignored; only reset exits.
- legal_dest is sampled only in SRC_HELD on a sel cycle; it is don't-care otherwise.
- move_done and illegal are never high in the same cycle.
- src==dst can never commit; the generator never flags src. If the src bit is set, own-piece reselect takes priority.

Test Plan:
- Release reset -> board_flat row7 col4 = 11001, row1 col0 = 00111, turn=0, all pulses 0.
- IDLE, cursor (6,4), sel; then cursor (4,4) with legal_dest bit36=1, sel -> two edges later board(4,4)=00101, board(6,4)=00000, turn=1, move_done one cycle, captured=00000.
- Black to move, sel (6,0) (white pawn) -> illegal one-cycle pulse, state IDLE, src_valid=0.
- Held src (1,0) black, sel and cancel asserted in the same cycle at legal (3,0) -> src_valid=0, board unchanged, no move_done.
- White pawn preset at (1,3), (0,3) empty, legal bit3=1, commit -> board(0,3)=10101 (promoted queen), turn toggles.
- Commit capturing black king 11011 -> captured=11011, game_over=1; subsequent sels produce no illegal and no board change until reset=0.
